load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the main decoder. It consumes memWrite, loadCtrl and storeCtrl, plus the ALU address and rs2 data.
- Drives a word-addressed data-memory bus with a req/gnt/rvalid handshake, byte-lane steering and load sign/zero extension.
- Holds the pipeline through a stall output until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed in REQ+WAIT before abort; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- reqValid  in  1  execute stage presents a memory op; held stable while stall=1
- memRead  in  1  load op
- memWrite  in  1  store op; wins if memRead is also 1
- loadCtrl  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW
- storeCtrl  in  2  00 SB, 01 SH, 10 SW; 11 treated as SW
- addr  in  32  byte address (ALU result)
- storeData  in  32  rs2 value
- stall  out  1  freeze upstream pipeline
- loadData  out  32  extended load result, valid with loadValid
- loadValid  out  1  one-cycle pulse
- busErr  out  1  one-cycle pulse on timeout
- misalign  out  1  one-cycle pulse (see Optional Feature)
- memReq  out  1  bus request
- memWe  out  1  1 = write
- memAddr  out  32  {addr[31:2],2'b00}
- memByteEn  out  4  byte lanes
- memWdata  out  32  lane-replicated store data
- memGnt  in  1  request accepted this cycle
- memRvalid  in  1  read data valid
- memRdata  in  32  read word

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; timeout counter 0; all registered outputs 0; stall forced 0; memReq drops immediately, including mid-transaction. Any late memRvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on reqValid & (memRead|memWrite), latch op/addr/ctrl/data and go to REQ. memReq rises on the next cycle.
  - REQ: memReq=1 with memAddr/memWe/memByteEn/memWdata held stable until memGnt. On memGnt: a store goes to DONE; a load goes to WAIT. memRvalid in REQ is ignored; read data never arrives earlier than the cycle after gnt.
  - WAIT: memReq=0. On memRvalid, register the extended data into loadData and go to DONE.
  - DONE: loadValid=1 for loads only; the registered result is presented. stall=0. reqValid is ignored. Always returns to IDLE.
- stall = (IDLE & reqValid & (memRead|memWrite)) | REQ | WAIT. Minimum stall is 2 cycles for a store (gnt in first REQ cycle) and 3 cycles for a load.
- Store lane rules:
  - SB: memWdata={4{data[7:0]}}, memByteEn=4'b0001<<addr[1:0].
  - SH: memWdata={2{data[15:0]}}, memByteEn = addr[1] ? 4'b1100 : 4'b0011.
  - SW: memWdata=data, memByteEn=4'b1111.
- Load extraction: shifted = memRdata >> (8*addr[1:0]).
  - LB sign-extends shifted[7:0]; LBU zero-extends it.
  - LH sign-extends shifted[15:0]; LHU zero-extends it.
  - LW uses the full word.
- memWe=0 and memByteEn=4'b0000 on loads. memWdata=0 whenever memReq=0.
- Timeout: counter clears on entry to REQ and increments every REQ/WAIT cycle. When it reaches TIMEOUT_CYCLES: busErr pulses in the DONE cycle, loadData=0, loadValid=0, memReq drops, FSM goes to DONE.
- loadData holds its last value outside DONE. loadValid, busErr and misalign are exactly one cycle wide.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - An access is misaligned if it is a half-word op with addr[0]=1, or a word op with addr[1:0]≠00.
  - On acceptance of a misaligned access, go IDLE→DONE directly with no memReq.
  - misalign pulses in DONE; loadValid=0; loadData unchanged; stall high for exactly one cycle.
- Undefined: misalign is tied 0; the access proceeds with lane rules applied to the raw addr bits (word ops ignore addr[1:0]; half-word ops ignore addr[0]).

Test Plan:
- SW addr=0x100 data=0x11223344, memGnt after 2 REQ cycles → memAddr=0x100, memWe=1, memByteEn=1111, memWdata=0x11223344; stall high 4 cycles; no loadValid.
- SB addr=0x101 data=0x000000AB, immediate gnt → memWdata=0xABABABAB, memByteEn=0010, memAddr=0x100.
- LB addr=0x103, memRdata=0x80FF1234 one cycle after gnt → loadData=0xFFFFFF80, loadValid one-cycle pulse; LHU addr=0x102 with same data → 0x000080FF.
- LW addr=0x200 with memGnt never asserted, TIMEOUT_CYCLES=8 → busErr pulse 8 cycles after REQ entry, loadValid=0, memReq low afterwards, stall released.
- With LSU_MISALIGN_TRAP_EN: LW addr=0x102 → misalign pulse, memReq never asserted, stall high 1 cycle; without the macro → memAddr=0x100 and a normal load.
- rst_n pulled low in WAIT → memReq, stall and loadValid at 0 immediately; memRvalid arriving after rst_n rises produces no loadValid.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit driving a word-addressed req/gnt/rvalid data bus
//   Inputs : clk, rst_n (async, active low), reqValid/memRead/memWrite/loadCtrl/storeCtrl/addr/storeData
//            from execute; memGnt/memRvalid/memRdata from the data memory
//   Outputs: stall to the pipeline; loadData/loadValid/busErr/misalign results;
//            memReq/memWe/memAddr/memByteEn/memWdata to the data memory
//   Param  : TIMEOUT_CYCLES bus cycles allowed in REQ+WAIT before the access is aborted
//   Macro  : LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  loadCtrl,
  input  logic [1:0]  storeCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        busErr,
  output logic        misalign,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [3:0]  memByteEn,
  output logic [31:0] memWdata,
  input  logic        memGnt,
  input  logic        memRvalid,
  input  logic [31:0] memRdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    lctrl_q, lctrl_d;
  logic [1:0]    sctrl_q, sctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ld_q, ld_d;
  logic          err_q, err_d;
  logic          mis_q, mis_d;
  logic          accept, mis_in, timeout;
  logic          ld_byte, ld_half, ld_sign, st_byte, st_half;
  logic [1:0]    off;
  logic [31:0]   shifted, ext, st_wdata;
  logic [3:0]    st_be;
  assign accept  = reqValid & (memRead | memWrite);
  assign timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`ifdef LSU_MISALIGN_TRAP_EN
  // Alignment is judged on the incoming op so a bad access never reaches the bus.
  assign mis_in = memWrite
    ? ((storeCtrl == 2'b01) & addr[0]) | (storeCtrl[1] & |addr[1:0])
    : ((loadCtrl[1:0] == 2'b01) & addr[0]) | (loadCtrl[1] & |addr[1:0]) | ((loadCtrl[1:0] == 2'b11) & |addr[1:0]);
`else
  assign mis_in = 1'b0;
`endif
  // Unlisted loadCtrl codes fall through to word; storeCtrl 11 behaves as SW.
  assign ld_byte = lctrl_q[1:0] == 2'b00;
  assign ld_half = lctrl_q[1:0] == 2'b01;
  assign ld_sign = ~lctrl_q[2];
  assign st_byte = sctrl_q == 2'b00;
  assign st_half = sctrl_q == 2'b01;
  // Sub-word offset honours only the address bits meaningful for the access size.
  assign off     = ld_byte ? addr_q[1:0] : ld_half ? {addr_q[1], 1'b0} : 2'b00;
  assign shifted = memRdata >> {off, 3'b000};
  assign ext     = ld_byte ? {{24{ld_sign & shifted[7]}}, shifted[7:0]}
                 : ld_half ? {{16{ld_sign & shifted[15]}}, shifted[15:0]}
                 : shifted;
  assign st_be    = st_byte ? 4'b0001 << addr_q[1:0] : st_half ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_wdata = st_byte ? {4{data_q[7:0]}} : st_half ? {2{data_q[15:0]}} : data_q;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    lctrl_d = lctrl_q;
    sctrl_d = sctrl_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = memWrite;
        addr_d  = addr;
        data_d  = storeData;
        lctrl_d = loadCtrl;
        sctrl_d = storeCtrl;
        cnt_d   = '0;
        err_d   = 1'b0;
        mis_d   = mis_in;
        state_d = mis_in ? DONE : REQ;
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (memGnt) state_d = we_q ? DONE : WAIT;
        else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          ld_d    = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (memRvalid) begin
          ld_d    = ext;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
          ld_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      lctrl_q <= '0;
      sctrl_q <= '0;
      cnt_q   <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lctrl_q <= lctrl_d;
      sctrl_q <= sctrl_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end
  // rst_n gates stall so the pipeline is released while reset is held even if reqValid stays high.
  assign stall     = rst_n & (((state_q == IDLE) & accept) | (state_q == REQ) | (state_q == WAIT));
  assign memReq    = state_q == REQ;
  assign memWe     = memReq & we_q;
  assign memAddr   = {addr_q[31:2], 2'b00};
  assign memByteEn = memWe ? st_be : 4'b0000;
  assign memWdata  = memWe ? st_wdata : 32'h0;
  assign loadData  = ld_q;
  assign loadValid = (state_q == DONE) & ~we_q & ~err_q & ~mis_q;
  assign busErr    = (state_q == DONE) & err_q;
  assign misalign  = (state_q == DONE) & mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a scripted memory responder
module tb_load_store_unit;
  localparam int TO = 8;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        reqValid = 1'b0, memRead = 1'b0, memWrite = 1'b0;
  logic [2:0]  loadCtrl = '0;
  logic [1:0]  storeCtrl = '0;
  logic [31:0] addr = '0, storeData = '0;
  logic        memGnt = 1'b0, memRvalid = 1'b0;
  logic [31:0] memRdata = '0;
  logic        stall, loadValid, busErr, misalign, memReq, memWe;
  logic [31:0] loadData, memAddr, memWdata;
  logic [3:0]  memByteEn;
  int          checks = 0, errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_ld = '0;
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .memRead(memRead), .memWrite(memWrite),
    .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .addr(addr), .storeData(storeData),
    .stall(stall), .loadData(loadData), .loadValid(loadValid), .busErr(busErr), .misalign(misalign),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memByteEn(memByteEn), .memWdata(memWdata),
    .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (loadValid) begin
    if (sb.size() == 0) check("sb_unexpected_lv", loadValid, 0);
    else check("sb_load_data", loadData, sb.pop_front());
  end
  // kind: 0 normal, 1 timeout, 2 misalign trap; gw = REQ cycles before gnt (-1 never)
  task automatic op(input logic we, input logic [2:0] lc, input logic [1:0] sc, input logic [31:0] a,
                    input logic [31:0] d, input int gw, input logic [31:0] rd, input logic [31:0] exp_ld,
                    input logic [3:0] exp_be, input logic [31:0] exp_wd, input int exp_st, input int kind);
    int   stalls = 0, reqc = 0;
    logic gnt_prev = 1'b0, first = 1'b1, fin = 1'b0;
    reqValid = 1'b1; memRead = !we; memWrite = we;
    loadCtrl = lc; storeCtrl = sc; addr = a; storeData = d;
    if (!we && kind == 0) begin
      sb.push_back(exp_ld);
      last_ld = exp_ld;
    end
    for (int c = 0; c < 64 && !fin; c++) begin
      #1;
      memRvalid = 1'b0;
      if (c == 0) check("accept_stall", stall, 1);
      if (stall) stalls++;
      else if (c > 0) fin = 1'b1;
      if (fin) begin
        check("done_busErr", busErr, kind == 1);
        check("done_misalign", misalign, kind == 2);
        check("done_loadValid", loadValid, !we && kind == 0);
        check("done_memReq", memReq, 0);
        if (kind == 1) check("timeout_loadData", loadData, 0);
        if (kind == 2) check("trap_loadData", loadData, last_ld);
        reqValid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      end
      if (memReq) begin
        if (first) begin
          check("req_addr", memAddr, {a[31:2], 2'b00});
          check("req_we", memWe, we);
          check("req_be", memByteEn, exp_be);
          if (we) check("req_wdata", memWdata, exp_wd);
          first = 1'b0;
        end
        memGnt = (reqc == gw);
        reqc++;
      end else memGnt = 1'b0;
      if (gnt_prev && !we) begin
        memRvalid = 1'b1;
        memRdata  = rd;
      end
      gnt_prev = memGnt;
      @(negedge clk);
    end
    memGnt = 1'b0; memRvalid = 1'b0;
    check("op_finished", fin, 1);
    check("stall_cycles", stalls, exp_st);
    if (kind == 2) check("trap_no_memReq", reqc, 0);
    #1;
    check("pulse_loadValid", loadValid, 0);
    check("pulse_busErr", busErr, 0);
    check("pulse_misalign", misalign, 0);
    check("idle_stall", stall, 0);
  endtask
  // Reset mid-transaction; optionally deliver a late rvalid once reset is released.
  task automatic rst_mid(input logic in_wait);
    reqValid = 1'b1; memRead = 1'b1; loadCtrl = 3'b010; addr = 32'h300;
    @(negedge clk);
    #1;
    check("rst_pre_memReq", memReq, 1);
    if (in_wait) begin
      memGnt = 1'b1;
      @(negedge clk);
      memGnt = 1'b0;
      #1;
      check("rst_pre_wait_stall", stall, 1);
    end
    rst_n = 1'b0;
    #1;
    check("rst_memReq", memReq, 0);
    check("rst_stall", stall, 0);
    check("rst_loadValid", loadValid, 0);
    reqValid = 1'b0; memRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (in_wait) begin
      memRvalid = 1'b1; memRdata = 32'hDEADBEEF;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      memRvalid = 1'b0;
      #1;
      check("late_rvalid_lv", loadValid, 0);
      check("late_rvalid_stall", stall, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_stall", stall, 0);
    check("reset_memReq", memReq, 0);
    check("reset_loadValid", loadValid, 0);
    check("reset_busErr", busErr, 0);
    check("reset_misalign", misalign, 0);
    check("reset_loadData", loadData, 0);
    check("reset_memWdata", memWdata, 0);
    check("reset_memByteEn", memByteEn, 0);
    rst_n = 1'b1;
    @(negedge clk);
    op(1, 3'b000, 2'b10, 32'h100, 32'h11223344, 2, 0, 0, 4'b1111, 32'h11223344, 4, 0);
    op(1, 3'b000, 2'b00, 32'h101, 32'h000000AB, 0, 0, 0, 4'b0010, 32'hABABABAB, 2, 0);
    op(1, 3'b000, 2'b01, 32'h106, 32'h0000BEEF, 1, 0, 0, 4'b1100, 32'hBEEFBEEF, 3, 0);
    op(1, 3'b000, 2'b11, 32'h10C, 32'hA5A5_0F0F, 0, 0, 0, 4'b1111, 32'hA5A50F0F, 2, 0);
    op(0, 3'b000, 2'b00, 32'h103, 0, 0, 32'h80FF1234, 32'hFFFFFF80, 4'b0000, 0, 3, 0);
    op(0, 3'b101, 2'b00, 32'h102, 0, 0, 32'h80FF1234, 32'h000080FF, 4'b0000, 0, 3, 0);
    op(0, 3'b001, 2'b00, 32'h102, 0, 1, 32'h80FF1234, 32'hFFFF80FF, 4'b0000, 0, 4, 0);
    op(0, 3'b100, 2'b00, 32'h101, 0, 0, 32'h80FF1234, 32'h00000012, 4'b0000, 0, 3, 0);
    op(0, 3'b010, 2'b00, 32'h200, 0, -1, 0, 0, 4'b0000, 0, TO + 1, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    op(0, 3'b010, 2'b00, 32'h102, 0, 0, 32'hCAFEF00D, 0, 4'b0000, 0, 1, 2);
`else
    op(0, 3'b010, 2'b00, 32'h102, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000, 0, 3, 0);
`endif
    op(0, 3'b010, 2'b00, 32'h204, 0, 0, 32'h12345678, 32'h12345678, 4'b0000, 0, 3, 0);
    rst_mid(1'b0);
    rst_mid(1'b1);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
